// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : load/store size encodings, FSM states and access legality check
// Rev 1.0
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  // Legal size for the direction and naturally aligned for that size.
  function automatic logic access_ok(input logic [2:0] size,
                                     input logic       we,
                                     input logic [1:0] off);
    logic ok;
    case (size)
      LDST_B:  ok = 1'b1;
      LDST_H:  ok = ~off[0];
      LDST_W:  ok = (off == 2'b00);
      LDST_BU: ok = ~we;
      LDST_HU: ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_data_align.sv
`default_nettype none
// ============================================================================
// lsu_data_align : byte enables, store lane replication, load extract/extend
// Rev 1.0
// ============================================================================
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic [31:0] ld_o
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = rd_i >> {off_i, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  always_comb begin
    be_o = 4'b0000;
    wd_o = wd_i;
    ld_o = 32'h0;
    case (size_i)
      LDST_B, LDST_BU: begin
        be_o = 4'b0001 << off_i;
        wd_o = {4{wd_i[7:0]}};
        ld_o = (size_i == LDST_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end
      LDST_H, LDST_HU: begin
        be_o = off_i[1] ? 4'b1100 : 4'b0011;
        wd_o = {2{wd_i[15:0]}};
        ld_o = (size_i == LDST_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      end
      LDST_W: begin
        be_o = 4'b1111;
        wd_o = wd_i;
        ld_o = rd_i;
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// riscv_lsu : load/store unit FSM with memory handshake and RF write-back
// Rev 1.0
// ============================================================================
module riscv_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  input  logic [4:0]  core_rd_i,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_wa_o,
  output logic [31:0] rf_wd_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        err_q, err_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_wa_q, rf_wa_d;
  logic [31:0] rf_wd_q, rf_wd_d;

  logic [2:0]  w_size;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_ld;

  // One aligner serves both phases: request fields in IDLE, latched fields afterwards.
  assign w_size = (state_q == LSU_IDLE) ? core_size_i      : size_q;
  assign w_off  = (state_q == LSU_IDLE) ? core_addr_i[1:0] : off_q;

  lsu_data_align u_align (
    .size_i (w_size),
    .off_i  (w_off),
    .wd_i   (core_wd_i),
    .rd_i   (mem_rd_i),
    .be_o   (w_be),
    .wd_o   (w_wd),
    .ld_o   (w_ld)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    off_d      = off_q;
    rd_d       = rd_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_be_d   = mem_be_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    err_d      = 1'b0;
    rf_we_d    = 1'b0;
    rf_wa_d    = rf_wa_q;
    rf_wd_d    = rf_wd_q;

    case (state_q)
      LSU_IDLE: begin
        if (core_req_i) begin
          if (access_ok(core_size_i, core_we_i, core_addr_i[1:0])) begin
            state_d    = LSU_WAIT;
            cnt_d      = '0;
            we_d       = core_we_i;
            size_d     = core_size_i;
            off_d      = core_addr_i[1:0];
            rd_d       = core_rd_i;
            mem_req_d  = 1'b1;
            mem_we_d   = core_we_i;
            mem_be_d   = w_be;
            mem_addr_d = {core_addr_i[31:2], 2'b00};
            mem_wd_d   = core_we_i ? w_wd : 32'h0;
          end else begin
            state_d = LSU_DONE;
            err_d   = 1'b1;
          end
        end
      end
      LSU_WAIT: begin
        // Ready is tested first so a response on the last allowed cycle still succeeds.
        if (mem_ready_i || (cnt_q == CW'(TIMEOUT - 1))) begin
          state_d    = LSU_DONE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_be_d   = 4'b0000;
          mem_addr_d = 32'h0;
          mem_wd_d   = 32'h0;
          if (mem_ready_i) begin
            if (!we_q) begin
              rf_we_d = 1'b1;
              rf_wa_d = rd_q;
              rf_wd_d = w_ld;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LSU_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      size_q     <= 3'd0;
      off_q      <= 2'd0;
      rd_q       <= 5'd0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 4'b0000;
      mem_addr_q <= 32'h0;
      mem_wd_q   <= 32'h0;
      err_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_wa_q    <= 5'd0;
      rf_wd_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      err_q      <= err_d;
      rf_we_q    <= rf_we_d;
      rf_wa_q    <= rf_wa_d;
      rf_wd_q    <= rf_wd_d;
    end
  end

  assign core_stall_o = ((state_q == LSU_IDLE) && core_req_i) || (state_q == LSU_WAIT);
  assign core_err_o   = err_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wd_o     = mem_wd_q;
  assign rf_we_o      = rf_we_q;
  assign rf_wa_o      = rf_wa_q;
  assign rf_wd_o      = rf_wd_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// tb_riscv_lsu : directed + randomized check of riscv_lsu against a byte-lane model
// Rev 1.0
// ============================================================================
module tb_riscv_lsu;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [2:0]  core_size_i = 3'd0;
  logic [31:0] core_addr_i = 32'h0;
  logic [31:0] core_wd_i = 32'h0;
  logic [4:0]  core_rd_i = 5'd0;
  logic        core_stall_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i = 32'h0;
  logic        mem_ready_i = 1'b0;
  logic        rf_we_o;
  logic [4:0]  rf_wa_o;
  logic [31:0] rf_wd_o;

  int checks = 0;
  int errors = 0;

  riscv_lsu #(.TIMEOUT(TO)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_i    (core_rd_i),
    .core_stall_o (core_stall_o),
    .core_err_o   (core_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i),
    .rf_we_o      (rf_we_o),
    .rf_wa_o      (rf_wa_o),
    .rf_wd_o      (rf_wd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes, or 0 when the request is rejected.
  function automatic int model_bytes(input bit we, input logic [2:0] size, input logic [31:0] addr);
    int n;
    case (size)
      3'd0:    n = 1;
      3'd1:    n = 2;
      3'd2:    n = 4;
      3'd4:    n = we ? 0 : 1;
      3'd5:    n = we ? 0 : 2;
      default: n = 0;
    endcase
    if (n != 0 && (addr % n) != 0) n = 0;
    return n;
  endfunction

  function automatic logic [3:0] model_be(input int n, input logic [31:0] addr);
    logic [3:0] be;
    int off;
    off = int'(addr % 4);
    be = 4'b0000;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input int n, input logic [31:0] wd);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_ld(input int n, input logic [2:0] size,
                                           input logic [31:0] addr, input logic [31:0] rdata);
    longint v;
    longint mask;
    v    = longint'(rdata) >> (8 * (addr % 4));
    mask = (longint'(1) << (8 * n)) - 1;
    v    = v & mask;
    if (size < 3'd4 && n < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
    return v[31:0];
  endfunction

  // One transaction from the request cycle through DONE; k = WAIT cycle with ready, 0 = never.
  task automatic do_access(input bit we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd, input int k,
                           input logic [31:0] rdata);
    int  n;
    bit  timed_out;
    bit  exp_rfwe;
    n = model_bytes(we, size, addr);
    check("idle_err", {31'h0, core_err_o}, 32'h0);
    check("idle_rfwe", {31'h0, rf_we_o}, 32'h0);
    core_req_i = 1'b1; core_we_i = we; core_size_i = size;
    core_addr_i = addr; core_wd_i = wd; core_rd_i = rd;
    #1;
    check("c0_stall", {31'h0, core_stall_o}, 32'h1);
    check("c0_mreq", {31'h0, mem_req_o}, 32'h0);
    @(posedge clk_i); #1;
    if (n != 0) begin
      for (int j = 1; j <= TO; j++) begin
        check("wait_mreq", {31'h0, mem_req_o}, 32'h1);
        check("wait_stall", {31'h0, core_stall_o}, 32'h1);
        check("wait_mwe", {31'h0, mem_we_o}, {31'h0, we});
        check("wait_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        check("wait_be", {28'h0, mem_be_o}, {28'h0, model_be(n, addr)});
        if (we) check("wait_wd", mem_wd_o, model_wd(n, wd));
        mem_ready_i = (j == k);
        mem_rd_i    = (j == k) ? rdata : $urandom;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        if (j == k) break;
      end
    end
    timed_out = (n != 0) && !(k >= 1 && k <= TO);
    exp_rfwe  = (n != 0) && !timed_out && !we;
    check("done_stall", {31'h0, core_stall_o}, 32'h0);
    check("done_mreq", {31'h0, mem_req_o}, 32'h0);
    check("done_err", {31'h0, core_err_o}, {31'h0, (n == 0) || timed_out});
    check("done_rfwe", {31'h0, rf_we_o}, {31'h0, exp_rfwe});
    if (exp_rfwe) begin
      check("done_rfwa", {27'h0, rf_wa_o}, {27'h0, rd});
      check("done_rfwd", rf_wd_o, model_ld(n, size, addr, rdata));
    end
    @(posedge clk_i); #1;
    core_req_i = 1'b0;
  endtask

  initial begin
    bit          r_we;
    logic [2:0]  r_size;
    int          r_k;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_stall", {31'h0, core_stall_o}, 32'h0);
    check("rst_err", {31'h0, core_err_o}, 32'h0);
    check("rst_mreq", {31'h0, mem_req_o}, 32'h0);
    check("rst_be", {28'h0, mem_be_o}, 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_rfwe", {31'h0, rf_we_o}, 32'h0);
    check("rst_rfwa", {27'h0, rf_wa_o}, 32'h0);
    check("rst_rfwd", rf_wd_o, 32'h0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Directed cases
    do_access(1'b0, 3'd2, 32'h0000_0100, 32'h0, 5'd7, 1, 32'hDEAD_BEEF);
    do_access(1'b0, 3'd0, 32'h0000_0103, 32'h0, 5'd3, 1, 32'h8012_3456);
    do_access(1'b0, 3'd4, 32'h0000_0103, 32'h0, 5'd4, 2, 32'h8012_3456);
    do_access(1'b0, 3'd1, 32'h0000_0102, 32'h0, 5'd5, 1, 32'h8012_3456);
    do_access(1'b0, 3'd5, 32'h0000_0102, 32'h0, 5'd0, 1, 32'h8012_3456);
    do_access(1'b1, 3'd0, 32'h0000_0201, 32'h0000_00AB, 5'd9, 3, 32'h0);
    do_access(1'b1, 3'd1, 32'h0000_0302, 32'h1234_5678, 5'd9, 1, 32'h0);
    do_access(1'b0, 3'd2, 32'h0000_0102, 32'h0, 5'd1, 1, 32'h0);
    do_access(1'b0, 3'd3, 32'h0000_0100, 32'h0, 5'd1, 1, 32'h0);
    do_access(1'b1, 3'd4, 32'h0000_0100, 32'h0, 5'd1, 1, 32'h0);
    do_access(1'b0, 3'd1, 32'h0000_0101, 32'h0, 5'd1, 1, 32'h0);
    do_access(1'b0, 3'd2, 32'h0000_0400, 32'h0, 5'd2, 0, 32'h0);
    do_access(1'b0, 3'd2, 32'h0000_0404, 32'h0, 5'd6, TO, 32'h0BAD_F00D);

    // Asynchronous reset in the middle of WAIT
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
    core_addr_i = 32'h0000_0500; core_rd_i = 5'd11;
    @(posedge clk_i); #1;
    check("mid_mreq_before", {31'h0, mem_req_o}, 32'h1);
    @(posedge clk_i); #2;
    core_req_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("mid_mreq", {31'h0, mem_req_o}, 32'h0);
    check("mid_stall", {31'h0, core_stall_o}, 32'h0);
    check("mid_rfwe", {31'h0, rf_we_o}, 32'h0);
    @(posedge clk_i); #1;
    mem_ready_i = 1'b1; mem_rd_i = 32'h1111_2222;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("post_rst_rfwe", {31'h0, rf_we_o}, 32'h0);
      check("post_rst_mreq", {31'h0, mem_req_o}, 32'h0);
    end
    mem_ready_i = 1'b0;

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      r_we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1:    r_size = 3'd0;
        2, 3:    r_size = 3'd1;
        4, 5:    r_size = 3'd2;
        6:       r_size = 3'd4;
        7:       r_size = 3'd5;
        default: r_size = 3'($urandom_range(0, 7));
      endcase
      r_k = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 4));
      do_access(r_we, r_size, $urandom, $urandom, 5'($urandom_range(0, 31)), r_k, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
